// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - frame constants, FSM state encoding and baud divisor helper for the UART transmitter
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t IDLE  = 2'd0;
  localparam tx_state_t START = 2'd1;
  localparam tx_state_t DATA  = 2'd2;
  localparam tx_state_t STOP  = 2'd3;

  // Truncating division: the bit period is rounded down to whole clocks.
  function automatic int baud_divisor(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with show-ahead read data and a separately held occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: flushing the pointers and count empties the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter fed from a byte FIFO, frames sent back-to-back
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 40000000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  import uart_pkg::*;

  localparam int BAUDDELAY = baud_divisor(CLK_FREQ, BAUDRATE);
  localparam int CNT_W     = (BAUDDELAY > 1) ? $clog2(BAUDDELAY) : 1;

  typedef logic [CNT_W-1:0]     baud_cnt_t;
  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  localparam baud_cnt_t RELOAD   = baud_cnt_t'(BAUDDELAY - 1);
  localparam bit_cnt_t  LAST_BIT = bit_cnt_t'(DATA_BITS - 1);

  tx_state_t              state;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [DATA_BITS-1:0]   fifo_rdata;
  bit_cnt_t               bit_cnt;
  baud_cnt_t              baud_cnt;
  logic                   tx_q;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   load;

  assign ready_o = !fifo_full;
  assign push    = valid_i && ready_o;
  assign tx_o    = tx_q;
  assign busy_o  = (state != IDLE) || !fifo_empty;

  // A byte is taken either from idle or at the last stop-bit cycle, so frames chain with no gap.
  assign load = !fifo_empty && ((state == IDLE) || ((state == STOP) && (baud_cnt == '0)));

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (data_i),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      tx_q      <= 1'b1;
      shift_reg <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shift_reg <= fifo_rdata;
            tx_q      <= 1'b0;
            baud_cnt  <= RELOAD;
            state     <= START;
          end
        end
        START: begin
          if (baud_cnt == '0) begin
            tx_q      <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= LAST_BIT;
            baud_cnt  <= RELOAD;
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt - baud_cnt_t'(1);
          end
        end
        DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= RELOAD;
            if (bit_cnt != '0) begin
              tx_q      <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
              bit_cnt   <= bit_cnt - bit_cnt_t'(1);
            end else begin
              tx_q  <= 1'b1;
              state <= STOP;
            end
          end else begin
            baud_cnt <= baud_cnt - baud_cnt_t'(1);
          end
        end
        STOP: begin
          if (baud_cnt == '0) begin
            if (load) begin
              shift_reg <= fifo_rdata;
              tx_q      <= 1'b0;
              baud_cnt  <= RELOAD;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - baud_cnt_t'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed scoreboard bench for uart_tx_fifo at BAUDDELAY=10
module tb_uart_tx_fifo;

  localparam int CLK_FREQ   = 1000000;
  localparam int BAUDRATE   = 100000;
  localparam int FIFO_DEPTH = 8;
  localparam int BAUDDELAY  = 10;
  localparam int FRAME      = 10 * BAUDDELAY;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready;
  logic       tx;
  logic       busy;
  logic [3:0] count;

  int         checks = 0;
  int         errors = 0;
  int         frames_seen = 0;
  int         exp_frames = 0;
  logic [7:0] sb[$];
  int         starts[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUDRATE   (BAUDRATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_i       (data),
    .valid_i      (valid),
    .ready_o      (ready),
    .tx_o         (tx),
    .busy_o       (busy),
    .fifo_count_o (count)
  );

  // Rising edge e happens at time 10e+5; the following falling edge maps back to e.
  function automatic int edge_now();
    return int'(($time - 5) / 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; holds data/valid until accepted, returns at the next falling edge.
  task automatic push_hold(input logic [7:0] d, output int e);
    logic acc;
    e = -1;
    acc = 1'b0;
    data = d;
    valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      acc = ready;
      @(posedge clk);
      if (acc) begin
        e = edge_now();
        sb.push_back(d);
        exp_frames++;
        break;
      end
      @(negedge clk);
    end
    chk("push_accept", acc, 1);
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
    @(negedge clk);
  endtask

  // Line monitor: decodes every frame, checks bit timing, compares against the scoreboard.
  initial begin
    logic [7:0] got;
    logic       shape_ok;
    logic       aborted;
    int         s;
    got = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        s = edge_now();
        shape_ok = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) aborted = 1'b1;
          if (i < BAUDDELAY) begin
            if (tx !== 1'b0) shape_ok = 1'b0;
          end else if (i >= 9 * BAUDDELAY) begin
            if (tx !== 1'b1) shape_ok = 1'b0;
          end else if ((i % BAUDDELAY) == 0) begin
            got[3'(i / BAUDDELAY - 1)] = tx;
          end else if (tx !== got[3'(i / BAUDDELAY - 1)]) begin
            shape_ok = 1'b0;
          end
        end
        if (!aborted) begin
          frames_seen++;
          starts.push_back(s);
          chk("frame_shape", shape_ok, 1);
          chk("frame_expected", (sb.size() != 0), 1);
          if (sb.size() != 0) chk("frame_data", got, sb.pop_front());
        end
      end
    end
  end

  initial begin
    int         e0;
    int         e;
    int         mism;
    int         mism_busy;
    int         frames_at;
    int         acc_e[10];
    logic [7:0] pat;
    logic       exp_bit;

    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_count", count, 0);
    rst_n = 1'b1;

    mism = 0;
    mism_busy = 0;
    repeat (500) begin
      @(negedge clk);
      if (tx !== 1'b1) mism++;
      if (busy !== 1'b0) mism_busy++;
    end
    chk("idle_tx", mism, 0);
    chk("idle_busy", mism_busy, 0);

    // Single byte 0x56: exact cycle-by-cycle line pattern.
    starts.delete();
    pat = 8'h56;
    push_hold(pat, e0);
    valid = 1'b0;
    chk("single_no_bypass", tx, 1);
    chk("single_busy_c0", busy, 1);
    mism = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k <= 10) exp_bit = 1'b0;
      else if (k >= 91) exp_bit = 1'b1;
      else exp_bit = pat[3'((k - 11) / 10)];
      if (tx !== exp_bit) mism++;
      if (k == 100) chk("single_busy_c100", busy, 1);
    end
    chk("single_line_pattern", mism, 0);
    @(negedge clk);
    chk("single_busy_c101", busy, 0);
    chk("single_tx_c101", tx, 1);
    chk("single_frames", starts.size(), 1);
    if (starts.size() != 0) chk("single_start_edge", starts[0], e0 + 1);

    // Back-to-back 0x00 then 0xFF.
    starts.delete();
    push_hold(8'h00, e);
    push_hold(8'hFF, e);
    valid = 1'b0;
    wait_drain("b2b_drain");
    chk("b2b_frames", starts.size(), 2);
    if (starts.size() == 2) chk("b2b_gap", starts[1] - starts[0], FRAME);

    // Valid held with 10 bytes: FIFO fills, 10th waits for the second pop.
    starts.delete();
    for (int i = 0; i < 9; i++) push_hold(8'(8'hC0 + i), acc_e[i]);
    mism = 0;
    for (int i = 1; i < 9; i++) if (acc_e[i] != acc_e[0] + i) mism++;
    chk("fill_consecutive", mism, 0);
    chk("fill_ready_low", ready, 0);
    chk("fill_count", count, FIFO_DEPTH);
    push_hold(8'hC9, acc_e[9]);
    valid = 1'b0;
    chk("tenth_accept_edge", acc_e[9], acc_e[0] + FRAME + 2);
    wait_drain("fill_drain");
    chk("fill_frames", starts.size(), 10);
    mism = 0;
    for (int i = 1; i < starts.size(); i++) if (starts[i] - starts[i-1] != FRAME) mism++;
    chk("fill_contiguous", mism, 0);
    chk("fill_sb_empty", sb.size(), 0);

    // Reset during data bit 3 of 0xA5 with three bytes queued.
    push_hold(8'hA5, e0);
    push_hold(8'h11, e);
    push_hold(8'h22, e);
    push_hold(8'h33, e);
    valid = 1'b0;
    repeat (42) @(negedge clk);
    chk("abort_pre_tx", tx, 0);
    chk("abort_pre_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_async_tx", tx, 1);
    chk("abort_async_count", count, 0);
    chk("abort_async_busy", busy, 0);
    sb.delete();
    exp_frames -= 4;
    frames_at = frames_seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", ready, 1);
    mism = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) mism++;
    end
    chk("abort_quiet", mism, 0);
    chk("abort_no_frames", frames_seen, frames_at);

    chk("total_frames", frames_seen, exp_frames);
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
